mux_scan_ctrl: RTL and testbench

- Upstream controller for the 4:1 single-bit mux (mux_4_ifelse): drives its `sel` and reads back its `out`.
- On a start request, steps `sel` through channels 0..3 and holds each for DWELL cycles.
- Samples the mux output at the end of each dwell and presents the assembled 4-bit snapshot on a valid/ready output port.
- Supports single-shot and continuous scanning.

---
 rtl/mux_scan_pkg.sv | 57 +++++
 rtl/mux_scan_ctrl_dwell_cnt.sv | 44 ++++
 rtl/mux_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the 4:1 mux scan controller.
//   state_t  : controller states (IDLE, SCAN, HOLD)
//   NUM_CH   : number of mux channels scanned
//   SEL_W    : width of the channel select
//   SNAP_W   : width of the assembled snapshot
//   LAST_CH  : highest channel index
// Helper functions pick the next enabled channel from a channel mask. Only the
// MUX_SCAN_MASK_EN build of mux_scan_ctrl calls them.
// ---------------------------------------------------------------------------
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int SNAP_W = 4;
  localparam logic [SEL_W-1:0] LAST_CH = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Lowest enabled channel in the mask. Returns 0 for an empty mask.
  function automatic logic [SEL_W-1:0] firstEn(input logic [SNAP_W-1:0] mask);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) res = SEL_W'(i);
    end
    return res;
  endfunction

  // True if some channel above cur is enabled.
  function automatic logic hasEnAfter(input logic [SNAP_W-1:0] mask,
                                      input logic [SEL_W-1:0] cur);
    logic res;
    res = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i > int'(cur) && mask[i]) res = 1'b1;
    end
    return res;
  endfunction

  // Lowest enabled channel above cur.
  function automatic logic [SEL_W-1:0] nextEn(input logic [SNAP_W-1:0] mask,
                                              input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i > int'(cur) && mask[i]) res = SEL_W'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_cnt.sv
// ---------------------------------------------------------------------------
// mux_scan_dwell_cnt
// Counts the cycles that one channel stays selected. It wraps to zero after
// DWELL cycles and pulses o_dwell_done on the last cycle of each dwell.
//   i_clk        : clock
//   i_rst        : asynchronous active-high reset
//   i_clr        : hold the count at zero. The controller asserts it whenever
//                  it is not scanning.
//   o_dwell_done : high while the count equals DWELL-1 and i_clr is low
// ---------------------------------------------------------------------------
module mux_scan_dwell_cnt #(
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_dwell_done
);

  // Reject DWELL values the counter cannot represent.
  if ((DWELL < 1) || (DWELL > 255) || ((2 ** CNT_W) <= DWELL)) begin : g_bad_param
    $error("mux_scan_dwell_cnt: DWELL must be 1..255 and below 2**CNT_W");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end     = (r_cnt == CNT_W'(DWELL - 1));
  assign o_dwell_done = w_at_end && !i_clr;

  // Free-running dwell counter. It wraps at DWELL-1 so consecutive channels
  // get equal dwell without an extra clear cycle between them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux_scan_ctrl
// Upstream controller for a 4:1 single-bit mux. It steps o_sel through the
// channels and holds each one for DWELL cycles. At the end of each dwell it
// samples i_mux_out. It then offers the assembled 4-bit snapshot on a
// valid/ready port.
//   i_clk / i_rst  : clock, asynchronous active-high reset
//   i_start        : scan request, accepted only in IDLE
//   i_cont         : continuous mode, sampled at each snapshot handshake
//   o_sel          : registered channel select to the mux
//   i_mux_out      : mux output fed back for sampling
//   o_busy         : high from start acceptance until the return to IDLE
//   o_snap         : snapshot; bit i was sampled with o_sel == i
//   o_snap_valid   : snapshot available
//   i_snap_ready   : consumer accepts the snapshot
//   i_ch_mask      : (MUX_SCAN_MASK_EN only) enabled channels. Masked
//                    channels are skipped and read back as 0.
// Optional feature macro: MUX_SCAN_MASK_EN
// ---------------------------------------------------------------------------
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cont,
  output logic [SEL_W-1:0]  o_sel,
  input  logic              i_mux_out,
  output logic              o_busy,
  output logic [SNAP_W-1:0] o_snap,
  output logic              o_snap_valid,
  input  logic              i_snap_ready
`ifdef MUX_SCAN_MASK_EN
  ,
  input  logic [SNAP_W-1:0] i_ch_mask
`endif
);

  state_t            r_state;
  logic [NUM_CH-2:0] r_shadow;
  logic [SNAP_W-1:0] w_capture;
  logic [SNAP_W-1:0] w_snap_next;
  logic [SEL_W-1:0]  w_first_sel;
  logic [SEL_W-1:0]  w_next_sel;
  logic              w_last_ch;
  logic              w_empty;
  logic              w_dwell_done;
  logic              w_cnt_clr;

  assign w_cnt_clr = (r_state != SCAN);

  mux_scan_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr        (w_cnt_clr),
    .o_dwell_done (w_dwell_done)
  );

  // Shadow bits merged with the live sample for the current channel. On the
  // last channel this is the full snapshot. On earlier channels its low bits
  // become the new shadow.
  always_comb begin
    w_capture        = {1'b0, r_shadow};
    w_capture[o_sel] = i_mux_out;
  end

`ifdef MUX_SCAN_MASK_EN
  logic [SNAP_W-1:0] r_mask;

  // Channel ordering follows the latched mask. The first channel comes from
  // the live mask, because the mask is latched on the same edge.
  assign w_first_sel = firstEn(i_ch_mask);
  assign w_next_sel  = nextEn(r_mask, o_sel);
  assign w_last_ch   = !hasEnAfter(r_mask, o_sel);
  assign w_empty     = (r_mask == '0);
  assign w_snap_next = w_capture & r_mask;

  // Latch the channel mask at every scan start, including continuous restarts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mask <= '0;
    end else if ((r_state == IDLE && i_start) ||
                 (r_state == HOLD && i_snap_ready && i_cont)) begin
      r_mask <= i_ch_mask;
    end
  end
`else
  // All four channels are scanned in order.
  assign w_first_sel = '0;
  assign w_next_sel  = o_sel + SEL_W'(1);
  assign w_last_ch   = (o_sel == LAST_CH);
  assign w_empty     = 1'b0;
  assign w_snap_next = w_capture;
`endif

  // Scan FSM with registered outputs. The snapshot is written only when a
  // scan completes, so it keeps its value through and after the handshake.
  // An empty mask completes the scan on the first SCAN cycle with a zero
  // snapshot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      o_sel        <= '0;
      o_busy       <= 1'b0;
      o_snap       <= '0;
      o_snap_valid <= 1'b0;
      r_shadow     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= SCAN;
            o_sel   <= w_first_sel;
            o_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (w_empty) begin
            o_snap       <= '0;
            o_snap_valid <= 1'b1;
            o_sel        <= '0;
            r_state      <= HOLD;
          end else if (w_dwell_done) begin
            if (w_last_ch) begin
              o_snap       <= w_snap_next;
              o_snap_valid <= 1'b1;
              o_sel        <= '0;
              r_state      <= HOLD;
            end else begin
              r_shadow <= w_capture[NUM_CH-2:0];
              o_sel    <= w_next_sel;
            end
          end
        end
        HOLD: begin
          if (i_snap_ready) begin
            o_snap_valid <= 1'b0;
            if (i_cont) begin
              r_state <= SCAN;
              o_sel   <= w_first_sel;
            end else begin
              r_state <= IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Drives two controllers, one with DWELL=1 and one with DWELL=3. Each one
// feeds a behavioural 4:1 mux, where chan[d] = {d,c,b,a}. A timeline model
// predicts the outputs of both controllers every cycle. The model works from
// the elapsed scan time: sel = t / DWELL, and channel k is sampled at
// t = DWELL*(k+1).
// Optional feature macro: MUX_SCAN_MASK_EN
// ---------------------------------------------------------------------------
module tb_mux_scan_ctrl;
  import mux_scan_pkg::*;

  localparam int NDUT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start  [NDUT];
  logic       cont   [NDUT];
  logic       ready  [NDUT];
  logic [3:0] chan   [NDUT];
  logic [1:0] sel    [NDUT];
  logic       busy   [NDUT];
  logic       valid  [NDUT];
  logic       muxOut [NDUT];
  logic [3:0] snap   [NDUT];
`ifdef MUX_SCAN_MASK_EN
  logic [3:0] mask   [NDUT];
`endif

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;
  bit modelOn     = 1'b1;

  // Timeline model state (mT = -1 when not scanning)
  int         mT     [NDUT];
  logic       mBusy  [NDUT];
  logic       mHold  [NDUT];
  logic       mValid [NDUT];
  logic [3:0] mSnap  [NDUT];
  logic [3:0] mCap   [NDUT];

  assign muxOut[0] = chan[0][sel[0]];
  assign muxOut[1] = chan[1][sel[1]];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(1), .CNT_W(8)) u_dut0 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start[0]),
    .i_cont       (cont[0]),
    .o_sel        (sel[0]),
    .i_mux_out    (muxOut[0]),
    .o_busy       (busy[0]),
    .o_snap       (snap[0]),
    .o_snap_valid (valid[0]),
    .i_snap_ready (ready[0])
`ifdef MUX_SCAN_MASK_EN
    ,
    .i_ch_mask    (mask[0])
`endif
  );

  mux_scan_ctrl #(.DWELL(3), .CNT_W(8)) u_dut1 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start[1]),
    .i_cont       (cont[1]),
    .o_sel        (sel[1]),
    .i_mux_out    (muxOut[1]),
    .o_busy       (busy[1]),
    .o_snap       (snap[1]),
    .o_snap_valid (valid[1]),
    .i_snap_ready (ready[1])
`ifdef MUX_SCAN_MASK_EN
    ,
    .i_ch_mask    (mask[1])
`endif
  );

  function automatic int dwellOf(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int expSel(input int d);
    return (mT[d] >= 0) ? mT[d] / dwellOf(d) : 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int d, input logic s, input logic c,
                               input logic r, input logic [3:0] ch);
    start[d] = s;
    cont[d]  = c;
    ready[d] = r;
    chan[d]  = ch;
  endtask

  task automatic modelReset();
    for (int d = 0; d < NDUT; d++) begin
      mT[d]     = -1;
      mBusy[d]  = 1'b0;
      mHold[d]  = 1'b0;
      mValid[d] = 1'b0;
      mSnap[d]  = 4'h0;
      mCap[d]   = 4'h0;
    end
  endtask

  // Advances the model across one rising edge, using the inputs present just
  // before that edge.
  task automatic modelStep();
    int k;
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        mT[d] = -1; mBusy[d] = 1'b0; mHold[d] = 1'b0;
        mValid[d] = 1'b0; mSnap[d] = 4'h0; mCap[d] = 4'h0;
      end else if (mT[d] >= 0) begin
        mT[d]++;
        if (mT[d] % dwellOf(d) == 0) begin
          k = mT[d] / dwellOf(d) - 1;
          mCap[d][k] = chan[d][k];
        end
        if (mT[d] == 4 * dwellOf(d)) begin
          mSnap[d]  = mCap[d];
          mValid[d] = 1'b1;
          mHold[d]  = 1'b1;
          mT[d]     = -1;
        end
      end else if (mHold[d]) begin
        if (ready[d]) begin
          mValid[d] = 1'b0;
          mHold[d]  = 1'b0;
          if (cont[d]) mT[d] = 0;
          else         mBusy[d] = 1'b0;
        end
      end else if (start[d]) begin
        mT[d]    = 0;
        mBusy[d] = 1'b1;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("%s sel dut%0d", tag, d), int'(sel[d]), expSel(d));
      checkOutput($sformatf("%s busy dut%0d", tag, d), int'(busy[d]), int'(mBusy[d]));
      checkOutput($sformatf("%s valid dut%0d", tag, d), int'(valid[d]), int'(mValid[d]));
      checkOutput($sformatf("%s snap dut%0d", tag, d), int'(snap[d]), int'(mSnap[d]));
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    cyc++;
    if (modelOn) checkAll("tick");
  endtask

  // Single-shot scan with ready held high. Checks the valid latency, the
  // snapshot and the return to idle.
  task automatic runScan(input int d, input logic [3:0] c, input logic [3:0] expSnap,
                         input int expLat, input string name);
    int n;
    applyStimulus(d, 1'b1, 1'b0, 1'b1, c);
    tick();
    applyStimulus(d, 1'b0, 1'b0, 1'b1, c);
    n = 0;
    while (!valid[d] && n < 40) begin
      tick();
      n++;
    end
    checkOutput({name, " latency"}, n, expLat);
    checkOutput({name, " snap"}, int'(snap[d]), int'(expSnap));
    tick();
    checkOutput({name, " busy after handshake"}, int'(busy[d]), 0);
  endtask

  typedef struct {
    int         dut;
    logic [3:0] chan;
    logic [3:0] expSnap;
    int         expLat;
  } vec_t;

  vec_t vecs [5];

  // Runs after a fixed time budget and aborts the simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, table vectors, hand-written corner cases,
  // randomized run.
  initial begin
    int n;
    int prev;
    logic [3:0] expChan;

    vecs[0] = '{0, 4'b1010, 4'b1010, 4};
    vecs[1] = '{1, 4'b0101, 4'b0101, 12};
    vecs[2] = '{0, 4'b0111, 4'b0111, 4};
    vecs[3] = '{1, 4'b1100, 4'b1100, 12};
    vecs[4] = '{1, 4'b1111, 4'b1111, 12};

    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      applyStimulus(d, 1'b0, 1'b0, 1'b0, 4'h0);
`ifdef MUX_SCAN_MASK_EN
      mask[d] = 4'hF;
`endif
    end
    #1;
    modelReset();
    checkAll("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 5; i++) begin
      runScan(vecs[i].dut, vecs[i].chan, vecs[i].expSnap, vecs[i].expLat,
              $sformatf("vec%0d", i));
      tick();
    end

    $display("[TB] hold stall with start pulses");
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'b0110);
    tick();
    start[1] = 1'b0;
    n = 0;
    while (!valid[1] && n < 40) begin tick(); n++; end
    checkOutput("stall valid rise", n, 12);
    for (int i = 0; i < 5; i++) begin
      start[1] = (i % 2 == 0);
      tick();
      checkOutput("stall valid held", int'(valid[1]), 1);
      checkOutput("stall snap held", int'(snap[1]), 4'b0110);
    end
    start[1] = 1'b1;
    ready[1] = 1'b1;
    tick();
    checkOutput("stall valid cleared", int'(valid[1]), 0);
    checkOutput("stall start ignored busy", int'(busy[1]), 0);
    checkOutput("stall snap kept", int'(snap[1]), 4'b0110);
    start[1] = 1'b0;
    tick();

    $display("[TB] continuous mode");
    expChan = 4'b1001;
    applyStimulus(1, 1'b1, 1'b1, 1'b1, expChan);
    tick();
    start[1] = 1'b0;
    prev = 0;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!valid[1] && n < 30) begin tick(); n++; end
      checkOutput("cont snap", int'(snap[1]), int'(expChan));
      if (s > 0) checkOutput("cont period", cyc - prev, 13);
      prev = cyc;
      expChan = 4'($urandom);
      chan[1] = expChan;
      tick();
      checkOutput("cont busy stays", int'(busy[1]), 1);
    end
    tick(); tick(); tick(); tick();
    cont[1] = 1'b0;
    n = 0;
    while (!valid[1] && n < 30) begin tick(); n++; end
    checkOutput("cont drop final snap", int'(snap[1]), int'(expChan));
    tick();
    checkOutput("cont drop idle", int'(busy[1]), 0);
    tick();

    $display("[TB] async reset mid-scan");
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 4'b1111);
    tick();
    start[1] = 1'b0;
    n = 0;
    while (sel[1] != 2'd2 && n < 20) begin tick(); n++; end
    checkOutput("reach sel2", int'(sel[1]), 2);
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput("abort sel", int'(sel[1]), 0);
    checkOutput("abort busy", int'(busy[1]), 0);
    checkOutput("abort valid", int'(valid[1]), 0);
    checkOutput("abort snap", int'(snap[1]), 0);
    tick();
    rst = 1'b0;
    tick();
    runScan(1, 4'b0011, 4'b0011, 12, "post-reset");
    tick();

`ifdef MUX_SCAN_MASK_EN
    $display("[TB] channel mask");
    modelOn = 1'b0;
    mask[1] = 4'b1010;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 4'b1111);
    tick();
    start[1] = 1'b0;
    expChan = 4'b0000;
    n = 0;
    while (!valid[1] && n < 40) begin
      if (busy[1]) expChan[sel[1]] = 1'b1;
      tick();
      n++;
    end
    checkOutput("mask latency", n, 6);
    checkOutput("mask snap", int'(snap[1]), 4'b1010);
    checkOutput("mask sel visited", int'(expChan), 4'b1010);
    ready[1] = 1'b1;
    tick();
    mask[1] = 4'b0000;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    ready[1] = 1'b0;
    tick();
    checkOutput("empty mask valid", int'(valid[1]), 1);
    checkOutput("empty mask snap", int'(snap[1]), 0);
    ready[1] = 1'b1;
    tick();
    mask[1] = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    modelOn = 1'b1;
    tick();
`endif

    $display("[TB] randomized run");
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < NDUT; d++) begin
        start[d] = ($urandom_range(0, 3) == 0);
        ready[d] = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 7) == 0) cont[d] = ~cont[d];
        chan[d] = 4'($urandom);
      end
      tick();
    end
    for (int d = 0; d < NDUT; d++) applyStimulus(d, 1'b0, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("drain idle dut0", int'(busy[0]), 0);
    checkOutput("drain idle dut1", int'(busy[1]), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
